// File: rtl/alu_func_stepper.sv
// alu_func_stepper
//   Clocked ALU front panel. Two raw push-buttons step a 3-bit function
//   select forward and backward. The select wraps around in both directions.
//   Each button is synchronised and debounced on-chip. A WIDTH-bit ALU
//   computes from a, b and the current select. Its result and status flags
//   are registered every cycle.
//
// Ports
//   clk          system clock, all state changes on posedge
//   rst_n        synchronous active-low reset
//   btn_next     raw button, an accepted press advances func
//   btn_prev     raw button, an accepted press decrements func
//   a, b         WIDTH-bit operands (two's complement for signed ops)
//   func         current function select (registered)
//   func_changed one-cycle pulse in the first cycle func shows a new value
//   y            registered ALU result
//   carry        registered carry-out / borrow flag
//   overflow     registered signed-overflow flag
//   zero         registered flag, high when y == 0
module alu_func_stepper #(
  parameter int         WIDTH           = 4,
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter logic [2:0] FUNC_RESET      = 3'b000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       func,
  output logic             func_changed,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  // A counter must hold values up to DEBOUNCE_CYCLES-1. It keeps at least 1 bit.
  localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] btn_raw;
  logic [1:0] rise;

  // Index 0 is the next button. Index 1 is the prev button.
  assign btn_raw = {btn_prev, btn_next};

  // ---------------------------------------------------------------------
  // Per-button synchroniser, debouncer and rising-edge detector
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             deb_q, deb_d;
    logic             deb_dly_q, deb_dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      s1_d      = btn_raw[gi];
      s2_d      = s1_q;
      deb_d     = deb_q;
      deb_dly_d = deb_q;
      cnt_d     = cnt_q;
      if (s2_q == deb_q) begin
        // No disagreement with the accepted level, so any streak is discarded.
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        deb_d = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        deb_q     <= 1'b0;
        deb_dly_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        s1_q      <= s1_d;
        s2_q      <= s2_d;
        deb_q     <= deb_d;
        deb_dly_q <= deb_dly_d;
        cnt_q     <= cnt_d;
      end
    end

    // Only the accepted press counts. A release produces no event.
    assign rise[gi] = deb_q & ~deb_dly_q;
  end

  // ---------------------------------------------------------------------
  // Function select stepping
  // ---------------------------------------------------------------------
  logic [2:0] func_q, func_d;
  logic       func_changed_q, func_changed_d;

  always_comb begin
    func_d         = func_q;
    func_changed_d = 1'b0;
    // Both rises in the same cycle cancel each other. The 3-bit add and
    // subtract wrap naturally at 7 and 0.
    unique case (rise)
      2'b01: begin
        func_d         = func_q + 3'd1;
        func_changed_d = 1'b1;
      end
      2'b10: begin
        func_d         = func_q - 3'd1;
        func_changed_d = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] y_q, y_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  // The extra top bit holds the carry-out of the add and the borrow of the
  // subtract. The subtract bit is set exactly when a < b unsigned.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    y_d        = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    unique case (func_q)
      3'b000: begin
        y_d        = sum_ext[WIDTH-1:0];
        carry_d    = sum_ext[WIDTH];
        overflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        y_d        = diff_ext[WIDTH-1:0];
        carry_d    = diff_ext[WIDTH];
        overflow_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010:  y_d = ~a;
      3'b011:  y_d = a & b;
      3'b100:  y_d = a | b;
      3'b101:  y_d = a ^ b;
      3'b110:  y_d = WIDTH'($signed(a) < $signed(b));
      default: y_d = WIDTH'(a == b);
    endcase
    zero_d = (y_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      func_q         <= FUNC_RESET;
      func_changed_q <= 1'b0;
      y_q            <= '0;
      carry_q        <= 1'b0;
      overflow_q     <= 1'b0;
      zero_q         <= 1'b1;
    end else begin
      func_q         <= func_d;
      func_changed_q <= func_changed_d;
      y_q            <= y_d;
      carry_q        <= carry_d;
      overflow_q     <= overflow_d;
      zero_q         <= zero_d;
    end
  end

  assign func         = func_q;
  assign func_changed = func_changed_q;
  assign y            = y_q;
  assign carry        = carry_q;
  assign overflow     = overflow_q;
  assign zero         = zero_q;

endmodule

// File: tb/tb_alu_func_stepper.sv
module tb_alu_func_stepper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_next;
  logic       btn_prev;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] func;
  logic       func_changed;
  logic [3:0] y;
  logic       carry;
  logic       overflow;
  logic       zero;

  int n_checks = 0;
  int n_errors = 0;

  alu_func_stepper #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .FUNC_RESET     (3'b000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .a           (a),
    .b           (b),
    .func        (func),
    .func_changed(func_changed),
    .y           (y),
    .carry       (carry),
    .overflow    (overflow),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end else begin
      $display("ok   %s observed=%0d", tag, obs);
    end
  endtask

  // Advance one clock edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_next = 1'b0;
    btn_prev = 1'b0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Hold the given buttons for `hold` cycles, then release them and let the
  // debouncer settle. Counts every func_changed pulse seen along the way.
  task automatic press(input logic nxt, input logic prv, input int hold, output int pulses);
    pulses   = 0;
    btn_next = nxt;
    btn_prev = prv;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (func_changed) pulses++;
    end
    btn_next = 1'b0;
    btn_prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (func_changed) pulses++;
    end
  endtask

  // Step forward until func reaches the target. At most 8 presses are made.
  task automatic goto_func(input logic [2:0] target);
    int p;
    for (int i = 0; i < 8 && func != target; i++) press(1'b1, 1'b0, 10, p);
    check("goto_func", 32'(func), 32'(target));
  endtask

  initial begin
    int         p;
    int         pulses;
    logic [2:0] exp_func;

    a = 4'd0;
    b = 4'd0;
    do_reset();

    // The design must come out of reset in its defined state.
    check("rst_func", 32'(func), 32'd0);
    check("rst_chg", 32'(func_changed), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Single press held for 10 cycles. The first sampling edge is edge k.
    // The kth tick brings the simulation just past edge k+i-1, so func should
    // change after the 7th tick (edge k+6).
    pulses   = 0;
    btn_next = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (func_changed) pulses++;
      if (i == 6) check("lat_before", 32'(func), 32'd0);
      if (i == 7) begin
        check("lat_func", 32'(func), 32'd1);
        check("lat_pulse", 32'(func_changed), 32'd1);
      end
      if (i == 8) check("pulse_width", 32'(func_changed), 32'd0);
    end
    btn_next = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (func_changed) pulses++;
    end
    check("hold_one_step", 32'(func), 32'd1);
    check("hold_pulses", 32'(pulses), 32'd1);

    // Wrap forward: 8 presses from 0 should give 1..7 and then 0.
    do_reset();
    exp_func = 3'd0;
    for (int i = 0; i < 8; i++) begin
      press(1'b1, 1'b0, 6, p);
      exp_func = exp_func + 3'd1;
      check("wrap_next", 32'(func), 32'(exp_func));
      check("wrap_next_pulses", 32'(p), 32'd1);
    end
    // Wrap backward from 0 to 7.
    press(1'b0, 1'b1, 6, p);
    check("wrap_prev", 32'(func), 32'd7);
    check("wrap_prev_pulses", 32'(p), 32'd1);

    // Bounce rejection. The button toggles every 2 cycles for 20 cycles and
    // then stays low, so no step may occur.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      btn_next = ((i / 2) % 2 == 0);
      tick();
      if (func_changed) pulses++;
    end
    btn_next = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (func_changed) pulses++;
    end
    check("bounce_func", 32'(func), 32'd7);
    check("bounce_pulses", 32'(pulses), 32'd0);

    // The same toggling followed by an 8-cycle hold gives exactly one step.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      btn_next = ((i / 2) % 2 == 0);
      tick();
      if (func_changed) pulses++;
    end
    press(1'b1, 1'b0, 8, p);
    check("bounce_hold_func", 32'(func), 32'd0);
    check("bounce_hold_pulses", 32'(pulses + p), 32'd1);

    // Simultaneous presses with func = 3 must cancel.
    do_reset();
    goto_func(3'd3);
    press(1'b1, 1'b1, 10, p);
    check("both_func", 32'(func), 32'd3);
    check("both_pulses", 32'(p), 32'd0);

    // Arithmetic with func = ADD.
    do_reset();
    a = 4'd7;
    b = 4'd1;
    check("add_lag", 32'(y), 32'd0);
    tick();
    check("add7_y", 32'(y), 32'd8);
    check("add7_ovf", 32'(overflow), 32'd1);
    check("add7_carry", 32'(carry), 32'd0);
    check("add7_zero", 32'(zero), 32'd0);
    a = 4'd15;
    b = 4'd1;
    tick();
    check("add15_y", 32'(y), 32'd0);
    check("add15_carry", 32'(carry), 32'd1);
    check("add15_zero", 32'(zero), 32'd1);
    check("add15_ovf", 32'(overflow), 32'd0);

    // SUB: 2 - 5 = 13 with a borrow.
    a = 4'd2;
    b = 4'd5;
    goto_func(3'd1);
    tick();
    check("sub_y", 32'(y), 32'd13);
    check("sub_carry", 32'(carry), 32'd1);
    check("sub_ovf", 32'(overflow), 32'd0);

    // NOT: ~5 = 10, and the flags are cleared.
    a = 4'd5;
    goto_func(3'd2);
    tick();
    check("not_y", 32'(y), 32'd10);
    check("not_carry", 32'(carry), 32'd0);

    // XOR: 12 ^ 10 = 6.
    a = 4'd12;
    b = 4'd10;
    goto_func(3'd5);
    tick();
    check("xor_y", 32'(y), 32'd6);

    // SLT: -8 < 1.
    a = 4'b1000;
    b = 4'd1;
    goto_func(3'd6);
    tick();
    check("slt_y", 32'(y), 32'd1);

    // EQ: 9 == 9. Changing b then makes the result 0 one cycle later.
    a = 4'd9;
    b = 4'd9;
    goto_func(3'd7);
    tick();
    check("eq_y", 32'(y), 32'd1);
    b = 4'd3;
    check("eq_lag", 32'(y), 32'd1);
    tick();
    check("neq_y", 32'(y), 32'd0);
    check("neq_zero", 32'(zero), 32'd1);

    // Reset in the middle of debounce. Move away from FUNC_RESET first.
    do_reset();
    goto_func(3'd2);
    btn_next = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("middeb_rst_func", 32'(func), 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (func_changed) pulses++;
    end
    press(1'b0, 1'b0, 0, p);
    check("middeb_func", 32'(func), 32'd1);
    check("middeb_pulses", 32'(pulses + p), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_func_stepper.md
Name: alu_func_stepper

Overview:
- Parametrised, clocked successor to the button-stepped 4-bit ALU front panel.
- Two raw push-buttons step the 3-bit function select forward and backward, with wrap-around in both directions.
- Buttons are synchronised and debounced on-chip.
- Contains its own WIDTH-bit ALU with registered result and status flags. Sits between board switches/buttons and LED/segment display logic.

Parameters:
- WIDTH, 4, operand and result width in bits; must be >= 2.
- DEBOUNCE_CYCLES, 4, number of consecutive stable synchronised samples required to accept a button level change; must be >= 1.
- FUNC_RESET, 3'b000, function select value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset.
- btn_next  input  1  raw asynchronous button; press advances func.
- btn_prev  input  1  raw asynchronous button; press decrements func.
- a  input  WIDTH  operand A; two's complement for signed ops.
- b  input  WIDTH  operand B.
- func  output  3  current function select (registered).
- func_changed  output  1  one-cycle pulse in the cycle func shows a new value.
- y  output  WIDTH  registered ALU result.
- carry  output  1  registered carry/borrow flag.
- overflow  output  1  registered signed-overflow flag.
- zero  output  1  registered flag, high when y == 0.

Behaviour:
- Reset: rst_n is sampled low at a posedge.
  - All outputs reset: func = FUNC_RESET; func_changed, y, carry, overflow = 0; zero = 1.
  - Synchroniser flops, debounced levels, edge registers and debounce counters all clear to 0.
  - A reset asserted mid-debounce discards the pending press; no step occurs after release of reset unless the button goes through a fresh accepted rise.
- Synchroniser: two flops per button (s1, s2).
- Debounce, per button:
  - deb level and counter cnt.
  - If s2 == deb: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: deb <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
- Edge detection: rise = deb & ~deb_q, where deb_q is deb delayed one cycle. Falls are ignored.
- Latency: raw button high first sampled at edge k → deb high at edge k+1+DEBOUNCE_CYCLES → func updates at edge k+2+DEBOUNCE_CYCLES. Glitches shorter than DEBOUNCE_CYCLES stable samples cause no step.
- Func update:
  - rise_next only: func <= func+1, 3'b111 wraps to 3'b000.
  - rise_prev only: func <= func-1, 3'b000 wraps to 3'b111.
  - Both in the same cycle: func unchanged, no pulse.
  - func_changed is high for exactly the one cycle after an edge that changed func.
  - Holding a button produces exactly one step.
- ALU: combinational on current a, b, func; all results registered every cycle, so y and flags lag a, b and func by one cycle.
  - 000 ADD: y = a+b mod 2^WIDTH; carry = carry-out; overflow = signed add overflow.
  - 001 SUB: y = a-b mod 2^WIDTH; carry = 1 when a < b unsigned (borrow); overflow = signed sub overflow.
  - 010 NOT: y = ~a.
  - 011 AND: y = a & b.
  - 100 OR: y = a | b.
  - 101 XOR: y = a ^ b.
  - 110 SLT: y = {0…, (signed a < signed b)}.
  - 111 EQ: y = {0…, a == b}.
  - For ops 010–111: carry = 0, overflow = 0.
  - zero reflects the registered y for every op.

Test Plan:
- Reset then step: hold rst_n low 2 cycles → func = 0, y = 0, zero = 1. Press btn_next for 10 cycles → func = 1 exactly at edge k+6 (DEBOUNCE_CYCLES = 4), func_changed high 1 cycle, no further step while held.
- Wrap both ways: 8 clean btn_next presses from 0 → func sequence 1..7, 0. Then btn_prev from 0 → 7.
- Bounce rejection: btn_next toggled every 2 cycles for 20 cycles, then low → func unchanged. Same toggling then held high 8 cycles → exactly one step.
- Simultaneous buttons: btn_next and btn_prev asserted on the same cycle for 10 cycles, with func = 3 → func stays 3, no func_changed.
- Arithmetic, WIDTH = 4:
  - ADD a=7, b=1 → y = 8, overflow = 1, carry = 0.
  - ADD a=15, b=1 → y = 0, carry = 1, zero = 1.
  - SUB a=2, b=5 → y = 13, carry = 1.
  - SLT a=-8, b=1 → y = 1.
  - EQ a=b=9 → y = 1.
  - Each result appears one cycle after the inputs.
- Reset mid-debounce: press btn_next, assert rst_n low at cycle 3 of the press for 1 cycle while the button stays high → func = FUNC_RESET, then exactly one step once debounce completes after reset.
